adder_disp_ctrl: RTL

Sequencer for the 4-bit adder / two-digit 7-segment display datapath (a, b, cin, en inputs). It owns the datapath operand and enable inputs and serves two sources. In manual mode it latches operands through a valid/ready load handshake. In sweep mode it self-steps through all 512 {cin,a,b} combinations with a programmable dwell per step, for on-board demo and self-check.

---
 rtl/adder_ctrl_pkg.sv | 15 +
 rtl/adder_disp_ctrl_dwell_timer.sv | 33 +++
 rtl/adder_disp_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared constants for the adder/display sequencer: state encoding,
// last sweep index and operand width.
package adder_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_SWEEP = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [8:0] SWEEP_LAST = 9'd511;
    localparam int         OPW        = 4;

endpackage

// File: rtl/adder_disp_ctrl_dwell_timer.sv
// Dwell counter for the sweep: counts while run is high and raises tick
// on the last cycle of each dwell period, then wraps to zero.
module dwell_timer #(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign tick = run && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (run)
            count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/adder_disp_ctrl.sv
// Operand/enable sequencer for the adder display datapath: manual loads via
// a valid/ready handshake, or an automatic sweep over all {cin,a,b} values.
module adder_disp_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 26
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic           ld_valid,
    output logic           ld_ready,
    input  logic [OPW-1:0] ld_a,
    input  logic [OPW-1:0] ld_b,
    input  logic           ld_cin,
    input  logic           pause,
    output logic [OPW-1:0] add_a,
    output logic [OPW-1:0] add_b,
    output logic           add_cin,
    output logic           disp_en,
    output logic           busy,
    output logic           sweep_done
);

    state_e           state_q, state_d;
    logic [8:0]       idx_q, idx_d;
    logic [OPW-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic             disp_en_q, disp_en_d;
    logic             done_q, done_d;
    logic             tick, tmr_clr, tmr_run, ld_fire;

    assign ld_ready = !rst && !mode && (state_q == S_IDLE || state_q == S_SHOW);
    assign ld_fire  = ld_valid && ld_ready;
    assign busy     = (state_q == S_SWEEP);

    // Timer is held cleared outside SWEEP and on the cycle the sweep aborts.
    assign tmr_clr = (state_q != S_SWEEP) || !mode;
    assign tmr_run = (state_q == S_SWEEP) && mode && !pause;

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES),
        .CNT_W       (CNT_W)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .run (tmr_run),
        .tick(tick)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        disp_en_d = disp_en_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE, S_SHOW: begin
                if (mode) begin
                    state_d   = S_SWEEP;
                    idx_d     = '0;
                    {add_cin_d, add_a_d, add_b_d} = '0;
                    disp_en_d = 1'b1;
                end else if (ld_fire) begin
                    state_d   = S_SHOW;
                    add_a_d   = ld_a;
                    add_b_d   = ld_b;
                    add_cin_d = ld_cin;
                    disp_en_d = 1'b1;
                end
            end
            S_SWEEP: begin
                if (!mode) begin
                    state_d   = S_IDLE;
                    idx_d     = '0;
                    {add_cin_d, add_a_d, add_b_d} = '0;
                    disp_en_d = 1'b0;
                end else if (tick) begin
                    if (idx_q == SWEEP_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 9'd1;
                        {add_cin_d, add_a_d, add_b_d} = idx_d;
                    end
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                idx_d     = '0;
                disp_en_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
            disp_en_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
            disp_en_q <= disp_en_d;
            done_q    <= done_d;
        end
    end

    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_cin    = add_cin_q;
    assign disp_en    = disp_en_q;
    assign sweep_done = done_q;

endmodule
